key_train_sequencer: RTL and testbench

KEY_TRAIN_SEQUENCER -- requirements
Module: key_train_sequencer

---
 rtl/key_train_sequencer_pkg.sv | 16 +
 rtl/key_train_sequencer_key_debounce.sv | 56 +++++
 rtl/key_train_sequencer.sv | 147 ++++++++++++++
 tb/tb_key_train_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_train_sequencer_pkg.sv
// Shared constants and FSM encoding for the key-entry training sequencer
// and the weight module it feeds.
package key_train_sequencer_pkg;

    localparam int W_ROWS        = 16;
    localparam int N_NEURONS_DEF = W_ROWS;
    localparam int ADDR_W        = 4;
    localparam int CNT_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_RUN  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/key_train_sequencer_key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low key.
// level_o is the registered level's next value, so a change is visible one cycle early.
module key_debounce
    import key_train_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Synchronizer and debounce state; reset loads the released level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle agreeing with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign level_o = level_d;

endmodule

// File: rtl/key_train_sequencer.sv
// Builds a training pattern from two push buttons, then issues one
// weight-row update request per neuron with a ready/ack handshake.
module key_train_sequencer
    import key_train_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int N_NEURONS  = N_NEURONS_DEF
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic                 key0,
    input  logic                 key1,
    output logic [1:0]           fsm,
    output logic [N_NEURONS-1:0] pattern,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic                 req,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [N_NEURONS-1:0] req_pattern,
    input  logic                 ack,
    output logic                 done,
    output logic [7:0]           led
);

    localparam logic [CNT_W-1:0]  RUN_LEN  = CNT_W'(N_NEURONS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_NEURONS - 1);

    logic deb0_s;
    logic deb1_s;

    fsm_state_e           state_q,       state_d;
    logic [N_NEURONS-1:0] pattern_q,     pattern_d;
    logic [CNT_W-1:0]     bit_cnt_q,     bit_cnt_d;
    logic                 pressed_q,     pressed_d;
    logic                 req_q,         req_d;
    logic [ADDR_W-1:0]    req_addr_q,    req_addr_d;
    logic [N_NEURONS-1:0] req_pattern_q, req_pattern_d;
    logic                 done_q,        done_d;

    logic [N_NEURONS-1:0] pattern_shift_s;
    logic [CNT_W-1:0]     bit_cnt_inc_s;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
        .clk_i   (CLOCK_50),
        .rst_i   (rst),
        .key_i   (key0),
        .level_o (deb0_s)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk_i   (CLOCK_50),
        .rst_i   (rst),
        .key_i   (key1),
        .level_o (deb1_s)
    );

    assign pattern_shift_s = {pattern_q[N_NEURONS-2:0], pressed_q};
    assign bit_cnt_inc_s   = bit_cnt_q + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            bit_cnt_q     <= '0;
            pressed_q     <= 1'b0;
            req_q         <= 1'b0;
            req_addr_q    <= '0;
            req_pattern_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            bit_cnt_q     <= bit_cnt_d;
            pressed_q     <= pressed_d;
            req_q         <= req_d;
            req_addr_q    <= req_addr_d;
            req_pattern_q <= req_pattern_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; debounced keys are active-low (0 = pressed).
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        bit_cnt_d     = bit_cnt_q;
        pressed_d     = pressed_q;
        req_d         = req_q;
        req_addr_d    = req_addr_q;
        req_pattern_d = req_pattern_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (deb0_s != deb1_s) begin
                    state_d   = ST_HELD;
                    pressed_d = ~deb1_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (deb0_s && deb1_s) begin
                    pattern_d = pattern_shift_s;
                    bit_cnt_d = bit_cnt_inc_s;
                    if (bit_cnt_inc_s == RUN_LEN) begin
                        state_d       = ST_RUN;
                        req_d         = 1'b1;
                        req_addr_d    = '0;
                        req_pattern_d = pattern_shift_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_RUN: begin
                if (req_q && ack) begin
                    if (req_addr_q == LAST_ROW) begin
                        req_d     = 1'b0;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        req_addr_d = req_addr_q + ADDR_W'(1);
                    end
                end else begin
                    req_d = req_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign fsm         = state_q;
    assign pattern     = pattern_q;
    assign bit_cnt     = bit_cnt_q;
    assign req         = req_q;
    assign req_addr    = req_addr_q;
    assign req_pattern = req_pattern_q;
    assign done        = done_q;
    assign led         = pattern_q[7:0];

endmodule

// File: tb/tb_key_train_sequencer.sv
// Directed bench for key_train_sequencer: key entry, debounce timing,
// training runs with different ack cadences, and reset mid-run.
module tb_key_train_sequencer;

    logic        CLOCK_50;
    logic        rst;
    logic        key0;
    logic        key1;
    logic [1:0]  fsm;
    logic [15:0] pattern;
    logic [4:0]  bit_cnt;
    logic        req;
    logic [3:0]  req_addr;
    logic [15:0] req_pattern;
    logic        ack;
    logic        done;
    logic [7:0]  led;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    int acc_count  = 0;

    key_train_sequencer #(.DEB_CYCLES(4), .N_NEURONS(16)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .key0        (key0),
        .key1        (key1),
        .fsm         (fsm),
        .pattern     (pattern),
        .bit_cnt     (bit_cnt),
        .req         (req),
        .req_addr    (req_addr),
        .req_pattern (req_pattern),
        .ack         (ack),
        .done        (done),
        .led         (led)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (done) done_count <= done_count + 1;
        if (req && ack) acc_count <= acc_count + 1;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic b, input int hold);
        if (b) key1 = 1'b0;
        else   key0 = 1'b0;
        repeat (hold) tick();
        key0 = 1'b1;
        key1 = 1'b1;
    endtask

    // Enters 16 bits MSB first; leaves the DUT on the cycle it enters RUN.
    task automatic enter16(input logic [15:0] seq);
        for (int i = 0; i < 15; i++) begin
            press(seq[15-i], 10);
            repeat (8) tick();
        end
        press(seq[0], 10);
        repeat (5) tick();
        check("pre_run_fsm", fsm, 32'd1);
        tick();
        check("run_fsm", fsm, 32'd2);
        check("run_req", req, 32'd1);
        check("run_addr0", req_addr, 32'd0);
        check("run_bitcnt", bit_cnt, 32'd16);
        check("run_req_pattern", req_pattern, seq);
    endtask

    initial begin
        int d0;
        int a0;
        int exp_acc;

        rst  = 1'b1;
        key0 = 1'b1;
        key1 = 1'b1;
        ack  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_fsm", fsm, 32'd0);
        check("rst_pattern", pattern, 32'd0);
        check("rst_bitcnt", bit_cnt, 32'd0);
        check("rst_req", req, 32'd0);
        check("rst_addr", req_addr, 32'd0);
        check("rst_req_pattern", req_pattern, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_led", led, 32'd0);

        // key1 low 10 cycles: HELD exactly 6 cycles after press and after release
        key1 = 1'b0;
        repeat (5) tick();
        check("press_lat_early", fsm, 32'd0);
        tick();
        check("press_lat_held", fsm, 32'd1);
        repeat (4) tick();
        key1 = 1'b1;
        repeat (5) tick();
        check("rel_lat_early", fsm, 32'd1);
        tick();
        check("rel_lat_idle", fsm, 32'd0);
        check("k1_pattern", pattern, 32'h0001);
        check("k1_bitcnt", bit_cnt, 32'd1);
        check("k1_led", led, 32'h01);
        repeat (4) tick();

        // key0 glitch of 3 cycles is rejected
        press(1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_fsm", fsm, 32'd0);
        end
        check("glitch_pattern", pattern, 32'h0001);
        check("glitch_bitcnt", bit_cnt, 32'd1);

        // both keys together are ignored
        key0 = 1'b0;
        key1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("both_fsm", fsm, 32'd0);
        end
        key0 = 1'b1;
        key1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("both_rel_fsm", fsm, 32'd0);
        end
        check("both_pattern", pattern, 32'h0001);
        check("both_bitcnt", bit_cnt, 32'd1);

        // clean start, then a run with ack tied high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_pattern", pattern, 32'd0);
        check("rst2_bitcnt", bit_cnt, 32'd0);
        ack = 1'b1;
        d0  = done_count;
        enter16(16'hCF99);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("fast_req", req, 32'd1);
            check("fast_addr", req_addr, i);
            check("fast_fsm", fsm, 32'd2);
            check("fast_req_pattern", req_pattern, 32'hCF99);
        end
        tick();
        check("fast_end_req", req, 32'd0);
        check("fast_end_done", done, 32'd1);
        check("fast_end_fsm", fsm, 32'd0);
        check("fast_end_bitcnt", bit_cnt, 32'd0);
        check("fast_end_pattern", pattern, 32'hCF99);
        tick();
        check("fast_done_clear", done, 32'd0);
        repeat (3) tick();
        check("fast_done_once", done_count - d0, 32'd1);
        ack = 1'b0;
        repeat (3) tick();

        // run with ack every third cycle; key0 pressed during the run
        d0 = done_count;
        enter16(16'h35A6);
        a0      = acc_count;
        exp_acc = 0;
        key0    = 1'b0;
        for (int c = 0; c < 48; c++) begin
            if (c == 9) key0 = 1'b1;
            ack = ((c % 3) == 2) ? 1'b1 : 1'b0;
            tick();
            if (ack) exp_acc++;
            if (exp_acc < 16) begin
                check("slow_req", req, 32'd1);
                check("slow_addr", req_addr, exp_acc);
                check("slow_req_pattern", req_pattern, 32'h35A6);
            end else begin
                check("slow_end_done", done, 32'd1);
                check("slow_end_req", req, 32'd0);
                check("slow_end_fsm", fsm, 32'd0);
            end
        end
        ack = 1'b0;
        repeat (3) tick();
        check("slow_acc_count", acc_count - a0, 32'd16);
        check("slow_done_once", done_count - d0, 32'd1);
        check("slow_fsm_idle", fsm, 32'd0);
        check("slow_pattern", pattern, 32'h35A6);
        check("slow_bitcnt", bit_cnt, 32'd0);

        // reset while row 7 is outstanding aborts the run
        d0 = done_count;
        enter16(16'hA5C3);
        ack = 1'b1;
        repeat (7) tick();
        check("abort_addr7", req_addr, 32'd7);
        rst = 1'b1;
        tick();
        check("abort_req", req, 32'd0);
        check("abort_fsm", fsm, 32'd0);
        check("abort_pattern", pattern, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_addr", req_addr, 32'd0);
        rst = 1'b0;
        ack = 1'b0;
        repeat (5) tick();
        check("abort_no_done", done_count - d0, 32'd0);
        check("abort_req_idle", req, 32'd0);
        check("abort_bitcnt", bit_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
